div_mul_sequencer: RTL and testbench
====================================

# div_mul_sequencer

Control-step sequencer for the CPU datapath. On a start request it walks the datapath through the fetch and execute T-states of one register-register instruction: fetch, Y load, ALU with Z load, writeback. It drives the datapath's bus-select, register-enable, memory-read and ALU-opcode controls. It replaces hand-timed testbench control with a synthesizable FSM. MUL/DIV results are written back to HI/LO; all other ALU ops write back to Rc.

## Interface
- No parameters (widths fixed by datapath: 16 GPRs, 5-bit ALU opcode, 32-bit IR).
- clk  in  1  datapath clock, rising edge.
- clr  in  1  reset. Synchronous, active-high.
- start  in  1  request one instruction; sampled only in IDLE.
- ir  in  32  datapath IR value. Fields: [31:27] op, [26:23] ra, [22:19] rb, [18:15] rc. Used only with fetch compiled in.
- op_in / ra_in / rb_in / rc_in  in  5/4/4/4  direct operands. Used only without fetch; latched on accepted start.
- mem_ready  in  1  memory data valid; gates exit from T1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLOin, ZHIin, ZLOout, ZHIout, Loin, HIin  out  1 each  datapath strobes.
- Rin, Rout  out  16  one-hot GPR enables.
- ALU_opcode  out  5  ALU operation.
- state  out  4  current state, for debug.

## Operation
- States: IDLE, T0–T6, DONE.
- IDLE: start=1 goes to T0 if fetch is compiled in, otherwise to T3.
- T0: PCout, MARin, IncPC, ZLOin.
- T1: ZLOout, PCin, Read, MDRin. Hold T1 while mem_ready=0; Read and MDRin stay high.
- T2: MDRout, IRin.
- T3: Rout[ra], Yin.
- T4: Rout[rb], ALU_opcode=op, ZLOin, ZHIin.
- T5:
  - MUL (5'b01111) or DIV (5'b10000): ZLOout, Loin, then go to T6.
  - Any other op: ZLOout, Rin[rc], then go to DONE.
- T6: ZHIout, HIin, then go to DONE.
- DONE: done=1, then go to IDLE.
- ALU_opcode is 0 in every state except T4.
- Outputs are a pure decode of the state register (Moore).
- In IDLE and after clr, every output is 0 and state=IDLE.
- start while busy is ignored, not queued.
- At most one bit of Rout and one bit of Rin is set in any cycle.
- ra=rb, or rc equal to ra/rb, is legal: the accesses fall in different T-states.

## Timing
- Start accepted at edge k.
- With fetch and mem_ready=1:
  - MUL/DIV: T0..T6 in cycles k+1..k+7, done in cycle k+8.
  - Other ops: done in cycle k+7.
  - Each mem_ready=0 cycle in T1 adds one cycle.
- Without fetch:
  - MUL/DIV: T3..T6 in cycles k+1..k+4, done in cycle k+5.
  - Other ops: done in cycle k+4.
- Back-to-back: next start is accepted no earlier than the IDLE cycle after DONE.
- clr=1 in any state: state=IDLE and all outputs 0 from the next cycle. Any in-flight instruction is abandoned with no done.
- clr wins over start on the same edge.

## Configuration
- DIV_MUL_SEQ_FETCH_EN defined:
  - T0–T2 present.
  - Operands decoded live from ir during T3–T6 (datapath holds IR stable).
  - op_in/ra_in/rb_in/rc_in ignored.
- Not defined:
  - T0–T2 unreachable; their strobes (PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin) are tied 0.
  - Operands latched from the *_in ports on accepted start.
  - ir and mem_ready ignored.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state encoding: IDLE=0, T0..T6=1..7, DONE=8.
  - opcode constants OP_MUL=5'b01111 and OP_DIV=5'b10000.
  - IR field bit positions.
- Sub-module reg_sel_decoder: 4-bit index plus enable to 16-bit one-hot. Instantiated twice, once for Rout and once for Rin.

## Test plan
- Reset: hold clr=1 for 2 cycles with start=1 → state=IDLE, busy=0, all strobes 0, Rin=Rout=0.
- No-fetch DIV, op_in=5'b10000, ra_in=6, rb_in=7 → next four cycles:
  - T3: Rout=16'h0040, Yin=1.
  - T4: Rout=16'h0080, ALU_opcode=10000, ZLOin=ZHIin=1.
  - T5: ZLOout=1, Loin=1.
  - T6: ZHIout=1, HIin=1.
  - Then done for one cycle.
- Fetch, ir op=5'b00011 (ADD), ra=2, rb=3, rc=1, mem_ready low for 2 cycles in T1 → T1 lasts 3 cycles with Read=1 throughout; T5 shows Rin=16'h0002 with ZLOout=1; no T6; done at k+9.
- Fetch MUL (5'b01111), mem_ready=1 → done exactly at k+8; HIin and Loin each high for exactly one cycle.
- start pulsed during T4 → ignored; exactly one done; IDLE follows.
- clr asserted in T4 → IDLE next cycle, all outputs 0, no done; a fresh start then completes normally.

Source files
------------

// File: rtl/div_mul_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU control sequencer:
//   - state_t      : sequencer state encoding (IDLE=0, T0..T6=1..7, DONE=8)
//   - OP_MUL/OP_DIV: ALU opcodes whose results go to HI/LO
//   - IR_*         : bit positions of the instruction register fields
//   - is_muldiv()  : true for opcodes that use the HI/LO writeback path
// ----------------------------------------------------------------------------
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/div_mul_sequencer_if.sv
// ----------------------------------------------------------------------------
// div_mul_sequencer_if
// Bundle between the control sequencer and the datapath / requester.
//   Requests : start, ir, op_in, ra_in, rb_in, rc_in, mem_ready
//   Status   : busy, done, state
//   Strobes  : PCout MARin IncPC PCin Read MDRin MDRout IRin Yin
//              ZLOin ZHIin ZLOout ZHIout Loin HIin, Rin/Rout (one-hot),
//              ALU_opcode
// master = sequencer side, slave = datapath / requester side.
// ----------------------------------------------------------------------------
interface div_mul_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic [4:0]  op_in;
    logic [3:0]  ra_in;
    logic [3:0]  rb_in;
    logic [3:0]  rc_in;
    logic        mem_ready;

    logic        busy;
    logic        done;
    logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, ZLOin, ZHIin, ZLOout, ZHIout, Loin, HIin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [4:0]  ALU_opcode;
    logic [3:0]  state;

    modport master (
        input  start, ir, op_in, ra_in, rb_in, rc_in, mem_ready,
        output busy, done, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout,
               IRin, Yin, ZLOin, ZHIin, ZLOout, ZHIout, Loin, HIin,
               Rin, Rout, ALU_opcode, state
    );

    modport slave (
        output start, ir, op_in, ra_in, rb_in, rc_in, mem_ready,
        input  busy, done, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout,
               IRin, Yin, ZLOin, ZHIin, ZLOout, ZHIout, Loin, HIin,
               Rin, Rout, ALU_opcode, state
    );
endinterface

// File: rtl/div_mul_sequencer_reg_sel_decoder.sv
// ----------------------------------------------------------------------------
// reg_sel_decoder
// 4-bit register index plus enable to 16-bit one-hot GPR select.
//   i_idx    : register index
//   i_en     : select enable; output is all-zero when low
//   o_onehot : one-hot enable, bit i_idx set when i_en
// ----------------------------------------------------------------------------
module reg_sel_decoder (
    input  logic [3:0]  i_idx,
    input  logic        i_en,
    output logic [15:0] o_onehot
);
    assign o_onehot = i_en ? (16'd1 << i_idx) : 16'd0;
endmodule

// File: rtl/div_mul_sequencer.sv
// ----------------------------------------------------------------------------
// div_mul_sequencer
// Moore FSM that walks the datapath through one register-register
// instruction: fetch (T0-T2), Y load (T3), ALU + Z load (T4), writeback
// (T5, plus T6 for the HI half of MUL/DIV).
//   clk : datapath clock, rising edge
//   clr : synchronous active-high reset
//   bus : div_mul_sequencer_if.master (requests in, strobes/status out)
// Build option: define DIV_MUL_SEQ_FETCH_EN to include the fetch T-states
// and decode operands from bus.ir; otherwise operands are latched from the
// *_in ports on an accepted start and the fetch strobes are tied low.
// ----------------------------------------------------------------------------
module div_mul_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    div_mul_sequencer_if.master bus
);
    state_t      r_state, w_next;
    logic [4:0]  w_op;
    logic [3:0]  w_ra, w_rb, w_rc;
    logic        w_accept;

    assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef DIV_MUL_SEQ_FETCH_EN
    // The datapath keeps IR stable for the whole instruction, so the
    // fields are decoded live rather than copied.
    assign w_op = bus.ir[IR_OP_MSB:IR_OP_LSB];
    assign w_ra = bus.ir[IR_RA_MSB:IR_RA_LSB];
    assign w_rb = bus.ir[IR_RB_MSB:IR_RB_LSB];
    assign w_rc = bus.ir[IR_RC_MSB:IR_RC_LSB];
    logic w_unused;
    assign w_unused = ^{bus.ir[IR_RC_LSB-1:0], bus.op_in, bus.ra_in,
                        bus.rb_in, bus.rc_in, w_accept};
`else
    logic [4:0] r_op;
    logic [3:0] r_ra, r_rb, r_rc;
    always_ff @(posedge clk) begin
        if (clr) begin
            r_op <= '0;
            r_ra <= '0;
            r_rb <= '0;
            r_rc <= '0;
        end else if (w_accept) begin
            r_op <= bus.op_in;
            r_ra <= bus.ra_in;
            r_rb <= bus.rb_in;
            r_rc <= bus.rc_in;
        end
    end
    assign w_op = r_op;
    assign w_ra = r_ra;
    assign w_rb = r_rb;
    assign w_rc = r_rc;
    logic w_unused;
    assign w_unused = ^{bus.ir, bus.mem_ready};
`endif

    // State register; clr has priority over any start on the same edge.
    always_ff @(posedge clk) begin
        if (clr) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
`ifdef DIV_MUL_SEQ_FETCH_EN
            S_IDLE: if (bus.start) w_next = S_T0;
            S_T0:   w_next = S_T1;
            S_T1:   if (bus.mem_ready) w_next = S_T2;
            S_T2:   w_next = S_T3;
`else
            S_IDLE: if (bus.start) w_next = S_T3;
`endif
            S_T3:   w_next = S_T4;
            S_T4:   w_next = S_T5;
            S_T5:   w_next = is_muldiv(w_op) ? S_T6 : S_DONE;
            S_T6:   w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strobe decode; everything defaults low so IDLE is all-zero.
    logic w_pcout, w_marin, w_incpc, w_pcin, w_read, w_mdrin, w_mdrout;
    logic w_irin, w_yin, w_zloin, w_zhiin, w_zloout, w_zhiout, w_loin, w_hiin;
    logic [4:0] w_alu_op;
    always_comb begin
        w_pcout  = 1'b0; w_marin  = 1'b0; w_incpc  = 1'b0; w_pcin   = 1'b0;
        w_read   = 1'b0; w_mdrin  = 1'b0; w_mdrout = 1'b0; w_irin   = 1'b0;
        w_yin    = 1'b0; w_zloin  = 1'b0; w_zhiin  = 1'b0; w_zloout = 1'b0;
        w_zhiout = 1'b0; w_loin   = 1'b0; w_hiin   = 1'b0;
        w_alu_op = 5'd0;
        case (r_state)
`ifdef DIV_MUL_SEQ_FETCH_EN
            S_T0: begin w_pcout = 1'b1; w_marin = 1'b1; w_incpc = 1'b1; w_zloin = 1'b1; end
            S_T1: begin w_zloout = 1'b1; w_pcin = 1'b1; w_read = 1'b1; w_mdrin = 1'b1; end
            S_T2: begin w_mdrout = 1'b1; w_irin = 1'b1; end
`endif
            S_T3: w_yin = 1'b1;
            S_T4: begin w_alu_op = w_op; w_zloin = 1'b1; w_zhiin = 1'b1; end
            S_T5: begin w_zloout = 1'b1; w_loin = is_muldiv(w_op); end
            S_T6: begin w_zhiout = 1'b1; w_hiin = 1'b1; end
            default: ;
        endcase
    end

    // T3 reads ra, T4 reads rb; Rin fires only for the non-HI/LO writeback.
    reg_sel_decoder u_rout_dec (
        .i_idx    ((r_state == S_T3) ? w_ra : w_rb),
        .i_en     ((r_state == S_T3) || (r_state == S_T4)),
        .o_onehot (bus.Rout)
    );

    reg_sel_decoder u_rin_dec (
        .i_idx    (w_rc),
        .i_en     ((r_state == S_T5) && !is_muldiv(w_op)),
        .o_onehot (bus.Rin)
    );

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.state      = r_state;
    assign bus.PCout      = w_pcout;
    assign bus.MARin      = w_marin;
    assign bus.IncPC      = w_incpc;
    assign bus.PCin       = w_pcin;
    assign bus.Read       = w_read;
    assign bus.MDRin      = w_mdrin;
    assign bus.MDRout     = w_mdrout;
    assign bus.IRin       = w_irin;
    assign bus.Yin        = w_yin;
    assign bus.ZLOin      = w_zloin;
    assign bus.ZHIin      = w_zhiin;
    assign bus.ZLOout     = w_zloout;
    assign bus.ZHIout     = w_zhiout;
    assign bus.Loin       = w_loin;
    assign bus.HIin       = w_hiin;
    assign bus.ALU_opcode = w_alu_op;
endmodule

// File: tb/tb_div_mul_sequencer.sv
// ----------------------------------------------------------------------------
// tb_div_mul_sequencer
// Directed, table-driven bench for div_mul_sequencer. Follows the build
// option DIV_MUL_SEQ_FETCH_EN: fetch adds three T-states ahead of T3.
// ----------------------------------------------------------------------------
module tb_div_mul_sequencer;
`ifdef DIV_MUL_SEQ_FETCH_EN
    localparam int OFF = 3;
`else
    localparam int OFF = 0;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    div_mul_sequencer_if bus ();

    div_mul_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Every output concatenated, for the "all zero" checks.
    logic [57:0] w_all;
    assign w_all = {bus.busy, bus.done, bus.PCout, bus.MARin, bus.IncPC,
                    bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
                    bus.Yin, bus.ZLOin, bus.ZHIin, bus.ZLOout, bus.ZHIout,
                    bus.Loin, bus.HIin, bus.Rin, bus.Rout, bus.ALU_opcode,
                    bus.state};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // done_cyc counts cycles after the accepting edge without fetch.
    typedef struct {
        logic [4:0]  op;
        logic [3:0]  ra, rb, rc;
        logic [15:0] rout3, rout4, rin5;
        logic        hi;
        int          done_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int ndone, nhi, nlo, last;
        ndone = 0; nhi = 0; nlo = 0;
        last  = v.done_cyc + OFF;
        @(negedge clk);
        bus.op_in = v.op; bus.ra_in = v.ra; bus.rb_in = v.rb; bus.rc_in = v.rc;
        bus.ir = {v.op, v.ra, v.rb, v.rc, 15'd0};
        bus.mem_ready = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.op_in = 5'd0; bus.ra_in = 4'd0; bus.rb_in = 4'd0; bus.rc_in = 4'd0;
        for (int c = 1; c <= last + 1; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (bus.HIin) nhi++;
            if (bus.Loin) nlo++;
`ifdef DIV_MUL_SEQ_FETCH_EN
            if (c == 1) chk("t0_pcout", {bus.PCout, bus.MARin, bus.IncPC, bus.ZLOin}, 4'hF);
            if (c == 2) chk("t1_read", {bus.ZLOout, bus.PCin, bus.Read, bus.MDRin}, 4'hF);
            if (c == 3) chk("t2_irin", {bus.MDRout, bus.IRin}, 2'b11);
`endif
            if (c == OFF + 1) begin
                chk("t3_state", bus.state, 4'd4);
                chk("t3_rout", bus.Rout, v.rout3);
                chk("t3_yin", bus.Yin, 1'b1);
            end
            if (c == OFF + 2) begin
                chk("t4_rout", bus.Rout, v.rout4);
                chk("t4_alu", bus.ALU_opcode, v.op);
                chk("t4_zin", {bus.ZLOin, bus.ZHIin}, 2'b11);
            end else begin
                chk("alu_zero", bus.ALU_opcode, 5'd0);
            end
            if (c == OFF + 3) begin
                chk("t5_zloout", bus.ZLOout, 1'b1);
                chk("t5_rin", bus.Rin, v.rin5);
                chk("t5_loin", bus.Loin, v.hi);
            end
            if (v.hi && c == OFF + 4)
                chk("t6_hi", {bus.ZHIout, bus.HIin, bus.Rin}, {2'b11, 16'h0});
            chk("done_pulse", bus.done, (c == last));
            if (c == last + 1) begin
                chk("idle_state", bus.state, 4'd0);
                chk("idle_all0", w_all, 58'd0);
            end
        end
        chk("done_count", ndone, 1);
        chk("hi_count", nhi, v.hi);
        chk("lo_count", nlo, v.hi);
    endtask

    initial begin
        int ndone;
        vecs[0] = '{5'b10000, 4'd6,  4'd7,  4'd0,  16'h0040, 16'h0080, 16'h0000, 1'b1, 5};
        vecs[1] = '{5'b00011, 4'd2,  4'd3,  4'd1,  16'h0004, 16'h0008, 16'h0002, 1'b0, 4};
        vecs[2] = '{5'b01111, 4'd15, 4'd0,  4'd9,  16'h8000, 16'h0001, 16'h0000, 1'b1, 5};
        vecs[3] = '{5'b01110, 4'd5,  4'd5,  4'd5,  16'h0020, 16'h0020, 16'h0020, 1'b0, 4};
        vecs[4] = '{5'b11111, 4'd0,  4'd15, 4'd15, 16'h0001, 16'h8000, 16'h8000, 1'b0, 4};
        vecs[5] = '{5'b10001, 4'd1,  4'd1,  4'd0,  16'h0002, 16'h0002, 16'h0001, 1'b0, 4};

        bus.start = 1'b1; bus.ir = 32'hFFFF_FFFF; bus.mem_ready = 1'b1;
        bus.op_in = 5'b01111; bus.ra_in = 4'd3; bus.rb_in = 4'd4; bus.rc_in = 4'd5;
        clr = 1'b1;

        // Reset with start held high: clr must win.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_all0", w_all, 58'd0);
        end
        bus.start = 1'b0;
        clr = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // start pulsed during T4 is ignored.
        @(negedge clk);
        bus.op_in = 5'b10000; bus.ra_in = 4'd6; bus.rb_in = 4'd7; bus.rc_in = 4'd0;
        bus.ir = {5'b10000, 4'd6, 4'd7, 4'd0, 15'd0};
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == OFF + 3) bus.start = 1'b0;
            if (bus.done) ndone++;
            if (c == OFF + 2) begin
                chk("busy_t4", bus.state, 4'd5);
                bus.start = 1'b1;
            end
        end
        chk("busy_start_done", ndone, 1);
        chk("busy_start_idle", w_all, 58'd0);

        // clr in T4 abandons the instruction.
        @(negedge clk);
        bus.op_in = 5'b00011; bus.ra_in = 4'd2; bus.rb_in = 4'd3; bus.rc_in = 4'd1;
        bus.ir = {5'b00011, 4'd2, 4'd3, 4'd1, 15'd0};
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (c == OFF + 3) begin
                chk("clr_all0", w_all, 58'd0);
                clr = 1'b0;
            end
            if (c == OFF + 2) begin
                chk("clr_t4", bus.state, 4'd5);
                clr = 1'b1;
            end
        end
        chk("clr_no_done", ndone, 0);
        run_vec(vecs[1]);

`ifdef DIV_MUL_SEQ_FETCH_EN
        // Memory stall: mem_ready low for two T1 cycles stretches T1 to three.
        begin
            int nread, dcyc;
            nread = 0; dcyc = 0;
            @(negedge clk);
            bus.ir = {5'b00011, 4'd2, 4'd3, 4'd1, 15'd0};
            bus.mem_ready = 1'b0;
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (bus.Read && bus.MDRin) nread++;
                if (bus.done && dcyc == 0) dcyc = c;
                if (c >= 2 && c <= 4) chk("stall_t1", bus.state, 4'd2);
                if (c == 4) bus.mem_ready = 1'b1;
                if (c == 8) chk("stall_t5", {bus.ZLOout, bus.Rin}, {1'b1, 16'h0002});
                if (c == 9) chk("stall_no_t6", bus.state, 4'd8);
            end
            chk("stall_read_cycles", nread, 3);
            chk("stall_done_cycle", dcyc, 9);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
